// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial WIDTH-bit adder sequencer built around one external 1-bit full
//   adder. A start pulse in IDLE latches both operands and the carry-in. Each
//   RUN cycle then presents one bit pair to the adder, LSB first, and feeds the
//   adder's carry-out back as the next carry-in. The sum is shifted in from the
//   MSB end. A one-cycle DONE state raises the done strobe.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   start          request pulse, only honoured in IDLE
//   op_a, op_b     operands, sampled when start is accepted
//   cin            initial carry-in, sampled when start is accepted
//   busy           high in RUN and DONE
//   done           one-cycle completion strobe (DONE state)
//   result, cout   sum and final carry; valid from done until the next accepted start
//   add_a, add_b   bit pair driven to the full adder
//   add_ci         carry driven to the full adder
//   add_sum        sum returned by the full adder
//   add_co         carry-out returned by the full adder
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             add_a,
  output logic             add_b,
  output logic             add_ci,
  input  logic             add_sum,
  input  logic             add_co
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;
  logic             last_bit;
  // The adder's sum bit enters at the MSB end. Building the shift as a
  // (WIDTH+1)-bit concatenation keeps it legal when WIDTH is 1.
  logic [WIDTH:0]   result_shift;

  assign last_bit     = (cnt_reg == CW'(WIDTH - 1));
  assign result_shift = {add_sum, result_reg};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The adder inputs come straight from registers, so they are
  // stable for the whole RUN cycle. They are forced low outside RUN.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    add_a  = 1'b0;
    add_b  = 1'b0;
    add_ci = 1'b0;
    case (state_reg)
      RUN: begin
        busy   = 1'b1;
        add_a  = sa_reg[0];
        add_b  = sb_reg[0];
        add_ci = carry_reg;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand shifters, carry feedback, bit counter and result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa_reg     <= '0;
      sb_reg     <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sa_reg    <= op_a;
            sb_reg    <= op_b;
            carry_reg <= cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          result_reg <= result_shift[WIDTH:1];
          carry_reg  <= add_co;
          sa_reg     <= sa_reg >> 1;
          sb_reg     <= sb_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_bit) begin
            cout_reg <= add_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign cout   = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  // WIDTH=8 instance
  logic       start;
  logic [7:0] op_a, op_b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] result;
  logic       add_a, add_b, add_ci, add_sum, add_co;
  // WIDTH=1 instance
  logic       start1;
  logic [0:0] op_a1, op_b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] result1;
  logic       add_a1, add_b1, add_ci1, add_sum1, add_co1;

  int total = 0;
  int bad   = 0;
  int cyc_abs = 0;

  // Values collected by do_op for the test tasks to compare
  logic [7:0] obs_result;
  logic       obs_cout;
  int         obs_done_cnt, obs_done_cyc, obs_done_abs, obs_busy_cnt, obs_lane_err;
  logic       obs_timeout;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  // Behavioural full adder for each instance
  assign add_sum  = add_a ^ add_b ^ add_ci;
  assign add_co   = (add_a & add_b) | (add_a & add_ci) | (add_b & add_ci);
  assign add_sum1 = add_a1 ^ add_b1 ^ add_ci1;
  assign add_co1  = (add_a1 & add_b1) | (add_a1 & add_ci1) | (add_b1 & add_ci1);

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_sum(add_sum), .add_co(add_co)
  );

  serial_add_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin(cin1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1),
    .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1), .add_sum(add_sum1), .add_co(add_co1)
  );

  // Runs one addition on the WIDTH=8 instance and records what it saw. It must
  // be called just after a falling edge, and it returns just after the falling
  // edge of the first IDLE cycle, so a following call starts back-to-back.
  // In cycles ign1/ign2 (1 = first RUN cycle), it pulses start with different
  // operands to probe that start is ignored while busy.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int ign1, input int ign2);
    int         cyc;
    logic [8:0] mask;
    logic [8:0] part;
    logic       exp_ci;
    logic       exp_a;
    logic       exp_b;
    logic       fin;
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    obs_done_cnt = 0; obs_done_cyc = 0; obs_done_abs = 0;
    obs_busy_cnt = 0; obs_lane_err = 0; obs_timeout = 1'b0;
    fin = 1'b0;
    for (int n = 0; n < 40; n++) begin
      start = 1'b0;
      if (busy) obs_busy_cnt++;
      if (done) begin
        obs_done_cnt++;
        obs_done_cyc = cyc;
        obs_done_abs = cyc_abs;
        obs_result = result;
        obs_cout = cout;
      end
      if (busy && !done && cyc <= 8) begin
        // Carry into bit i is bit i of the sum of the lower i bits plus cin
        mask   = (9'd1 << (cyc - 1)) - 9'd1;
        part   = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {8'd0, c};
        exp_ci = part[cyc - 1];
        exp_a  = a[cyc - 1];
        exp_b  = b[cyc - 1];
        if (add_ci !== exp_ci || add_a !== exp_a || add_b !== exp_b) obs_lane_err++;
      end
      if (obs_done_cnt > 0 && !busy) begin
        fin = 1'b1;
        break;
      end
      if (cyc == ign1 || cyc == ign2) begin
        start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) obs_timeout = 1'b1;
    $display("op %h + %h + %0d -> result=%h cout=%0d done_cyc=%0d busy_cycles=%0d",
             a, b, c, obs_result, obs_cout, obs_done_cyc, obs_busy_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    start1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0;
    #3;
    total++;
    if ({busy, done, cout, add_a, add_b, add_ci, result} !== 14'd0) begin
      bad++;
      $display("FAIL reset8 outputs got %h want 0", {busy, done, cout, add_a, add_b, add_ci, result});
    end
    total++;
    if ({busy1, done1, cout1, add_a1, add_b1, add_ci1, result1} !== 7'd0) begin
      bad++;
      $display("FAIL reset1 outputs got %h want 0", {busy1, done1, cout1, add_a1, add_b1, add_ci1, result1});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got %0d want 0", busy); end
  endtask

  task automatic test_basic();
    do_op(8'h5A, 8'h3C, 1'b0, 0, 0);
    total++;
    if ({obs_cout, obs_result} !== 9'h096) begin
      bad++; $display("FAIL basic_sum got %h want 096", {obs_cout, obs_result});
    end
    total++;
    if (obs_done_cyc !== 9 || obs_done_cnt !== 1) begin
      bad++; $display("FAIL basic_done got cyc=%0d cnt=%0d want cyc=9 cnt=1", obs_done_cyc, obs_done_cnt);
    end
    total++;
    if (obs_busy_cnt !== 9) begin bad++; $display("FAIL basic_busy got %0d want 9", obs_busy_cnt); end
    total++;
    if (obs_lane_err !== 0 || obs_timeout !== 1'b0) begin
      bad++; $display("FAIL basic_lanes got err=%0d timeout=%0d want 0 0", obs_lane_err, obs_timeout);
    end
    total++;
    if (result !== 8'h96 || cout !== 1'b0) begin
      bad++; $display("FAIL basic_hold got %h/%0d want 96/0", result, cout);
    end
  endtask

  task automatic test_carry_ripple();
    do_op(8'hFF, 8'h01, 1'b0, 0, 0);
    total++;
    if ({obs_cout, obs_result} !== 9'h100 || obs_lane_err !== 0) begin
      bad++; $display("FAIL ripple1 got %h err=%0d want 100 err=0", {obs_cout, obs_result}, obs_lane_err);
    end
    do_op(8'hFF, 8'h00, 1'b1, 0, 0);
    total++;
    if ({obs_cout, obs_result} !== 9'h100 || obs_lane_err !== 0) begin
      bad++; $display("FAIL ripple2 got %h err=%0d want 100 err=0", {obs_cout, obs_result}, obs_lane_err);
    end
  endtask

  task automatic test_ignore_start();
    do_op(8'h12, 8'h34, 1'b0, 3, 9);
    total++;
    if ({obs_cout, obs_result} !== 9'h046) begin
      bad++; $display("FAIL ignore_sum got %h want 046", {obs_cout, obs_result});
    end
    total++;
    if (obs_done_cnt !== 1 || obs_busy_cnt !== 9 || obs_lane_err !== 0) begin
      bad++; $display("FAIL ignore_ctrl got done=%0d busy=%0d err=%0d want 1 9 0",
                      obs_done_cnt, obs_busy_cnt, obs_lane_err);
    end
    // One more cycle: the start pulse in DONE must not have launched a new run
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore_relaunch busy got %0d want 0", busy); end
  endtask

  task automatic test_async_reset();
    int dcount;
    op_a = 8'hFF; op_b = 8'h00; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1 || add_a !== 1'b1 || result === 8'h00) begin
      bad++; $display("FAIL areset_pre got busy=%0d add_a=%0d result=%h want 1 1 nonzero", busy, add_a, result);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, cout, add_a, add_b, add_ci, result} !== 14'd0) begin
      bad++; $display("FAIL areset_clear got %h want 0", {busy, done, cout, add_a, add_b, add_ci, result});
    end
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    total++;
    if (dcount !== 0) begin bad++; $display("FAIL areset_nodone got %0d want 0", dcount); end
    do_op(8'h01, 8'h01, 1'b0, 0, 0);
    total++;
    if ({obs_cout, obs_result} !== 9'h002) begin
      bad++; $display("FAIL areset_fresh got %h want 002", {obs_cout, obs_result});
    end
  endtask

  task automatic test_back_to_back();
    int first_abs;
    do_op(8'h80, 8'h80, 1'b0, 0, 0);
    first_abs = obs_done_abs;
    total++;
    if ({obs_cout, obs_result} !== 9'h100 || obs_lane_err !== 0) begin
      bad++; $display("FAIL b2b_first got %h err=%0d want 100 err=0", {obs_cout, obs_result}, obs_lane_err);
    end
    do_op(8'h0F, 8'h01, 1'b1, 0, 0);
    total++;
    if ({obs_cout, obs_result} !== 9'h011 || obs_lane_err !== 0) begin
      bad++; $display("FAIL b2b_second got %h err=%0d want 011 err=0", {obs_cout, obs_result}, obs_lane_err);
    end
    total++;
    if (obs_done_abs - first_abs !== 10) begin
      bad++; $display("FAIL b2b_spacing got %0d want 10", obs_done_abs - first_abs);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic       c;
    logic [8:0] want;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      want = {1'b0, a} + {1'b0, b} + {8'd0, c};
      do_op(a, b, c, 0, 0);
      total++;
      if ({obs_cout, obs_result} !== want || obs_lane_err !== 0 || obs_done_cyc !== 9) begin
        bad++;
        $display("FAIL random_%0d got %h err=%0d cyc=%0d want %h err=0 cyc=9",
                 i, {obs_cout, obs_result}, obs_lane_err, obs_done_cyc, want);
      end
    end
  endtask

  task automatic test_width1();
    op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    total++;
    if ({busy1, done1, add_a1, add_b1, add_ci1} !== 5'b10111) begin
      bad++; $display("FAIL w1_run got %b want 10111", {busy1, done1, add_a1, add_b1, add_ci1});
    end
    @(negedge clk);
    total++;
    if ({busy1, done1, cout1, result1} !== 4'b1111) begin
      bad++; $display("FAIL w1_done got %b want 1111", {busy1, done1, cout1, result1});
    end
    @(negedge clk);
    total++;
    if ({busy1, done1, cout1, result1} !== 4'b0011) begin
      bad++; $display("FAIL w1_idle got %b want 0011", {busy1, done1, cout1, result1});
    end
    $display("op w1 1 + 1 + 1 -> result=%0d cout=%0d", result1, cout1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that performs a WIDTH-bit addition bit-serially on the external gate-level 1-bit full adder (addbit).
- Latches two operands and a carry-in on a start pulse.
- Presents one bit pair per clock to the adder, LSB first, and feeds the adder's carry-out back as the next carry-in.
- Assembles the sum, then signals completion.
- Sits between a requesting test bench or controller and a single addbit instance, owning all three addbit inputs.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op_a  input  WIDTH  operand A; sampled when start accepted
op_b  input  WIDTH  operand B; sampled when start accepted
cin  input  1  initial carry-in; sampled when start accepted
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion strobe
result  output  WIDTH  sum bits; valid from done, held until next accepted start
cout  output  1  final carry-out; valid from done, held until next accepted start
add_a  output  1  to addbit a
add_b  output  1  to addbit b
add_ci  output  1  to addbit ci
add_sum  input  1  from addbit sum
add_co  input  1  from addbit co

Behaviour:
- Reset (async assert, takes effect immediately):
  - State goes to IDLE.
  - busy, done, result, cout, add_a, add_b and add_ci all become 0.
  - Shift registers, carry register and bit counter are cleared.
  - Reset mid-operation aborts it; no done strobe is issued.
- States are IDLE, RUN and DONE.
- IDLE:
  - add_a, add_b and add_ci are driven 0.
  - start=1 at an edge loads sa<=op_a, sb<=op_b, carry<=cin and cnt<=0, then moves to RUN.
  - start=0 keeps the block in IDLE.
- RUN:
  - add_a=sa[0], add_b=sb[0] and add_ci=carry are driven combinationally from registers, so they are stable for the whole cycle.
  - At each edge:
    - shift add_sum into result from the MSB end (result <= {add_sum, result[WIDTH-1:1]});
    - carry<=add_co;
    - shift sa and sb right by one;
    - cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge: capture that bit as above, set cout<=add_co, and move to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then return to IDLE.
  - add_* are driven 0.
- Latency: start sampled at edge k gives RUN for cycles k+1..k+WIDTH. done is high in cycle k+WIDTH+1. busy is high for WIDTH+1 cycles.
- start while busy=1 (RUN or DONE) is ignored; operands are not re-sampled and there is no error indication.
- The earliest back-to-back start is accepted at the edge that ends DONE+1, i.e. the first IDLE cycle.
- Arithmetic: {cout, result} = op_a + op_b + cin, modulo 2^(WIDTH+1); no overflow flag.
- cnt is $clog2(WIDTH)+1 bits wide. WIDTH=1 yields a single RUN cycle.
- Timing: the clock period must exceed the addbit combinational delay (4 time units worst case: xor #2 then or #2). The bench uses a 10 ns period.
- result and cout are held unchanged in IDLE until the next accepted start. During RUN, partial shift contents are visible on result but are not valid.

Test Plan:
1. WIDTH=8, op_a=8'h5A, op_b=8'h3C, cin=0, start at edge k -> busy high k+1..k+9; done high only in cycle k+9; result=8'h96, cout=0.
2. op_a=8'hFF, op_b=8'h01, cin=0 -> result=8'h00, cout=1. Then op_a=8'hFF, op_b=8'h00, cin=1 -> result=8'h00, cout=1; full carry ripple across all 8 serial steps.
3. Start accepted with 8'h12+8'h34. Pulse start with 8'hFF+8'hFF at k+3 and during the DONE cycle -> both ignored; result=8'h46, cout=0; exactly one done strobe.
4. Assert reset asynchronously mid-clock during RUN cycle 4 -> busy, done, result, cout and add_* become 0 before the next edge; no done. A fresh start of 8'h01+8'h01 after release -> result=8'h02.
5. Back-to-back: 8'h80+8'h80, cin=0 (result=8'h00, cout=1), then start in the first IDLE cycle with 8'h0F+8'h01, cin=1 (result=8'h11, cout=0) -> two done strobes exactly 10 cycles apart. Check add_ci in every RUN cycle against the expected ripple.
6. WIDTH=1, op_a=1, op_b=1, cin=1 -> one RUN cycle, done in cycle k+2, result=1, cout=1.
